// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_BUSY,
        MC_DONE
    } mc_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard controller
interface hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  Rs1D;
    logic [RA_W-1:0]  Rs2D;
    logic [RA_W-1:0]  Rs1E;
    logic [RA_W-1:0]  Rs2E;
    logic [RA_W-1:0]  RdE;
    logic [RA_W-1:0]  RdM;
    logic [RA_W-1:0]  RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             McStartE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             McBusyE;
    logic             McDoneE;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE,
        input  StallF, StallD, StallE, FlushD, FlushE,
        input  ForwardAE, ForwardBE, McBusyE, McDoneE, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE,
        output StallF, StallD, StallE, FlushD, FlushE,
        output ForwardAE, ForwardBE, McBusyE, McDoneE, StallCycles
    );
endinterface

// File: rtl/hazard_ctrl_mc_sequencer.sv
// rtl/hazard_ctrl_mc_sequencer.sv - multi-cycle E-stage op sequencer (MUL/DIV freeze)
module mc_sequencer
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic McStartE,
    input  logic PCSrcE,
    output logic busy,
    output logic done,
    output logic hold
);
    localparam int CW       = $clog2(MC_LATENCY) + 1;
    localparam int BUSY_CYC = MC_LATENCY - 2;
    // cnt holds the number of BUSY cycles still to come after the current one
    localparam logic [CW-1:0] LOAD = CW'((BUSY_CYC > 0) ? BUSY_CYC - 1 : 0);

    mc_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        case (state)
            MC_IDLE: begin
                // a taken branch kills the op in E, so it never starts
                if (McStartE && !PCSrcE) begin
                    hold = 1'b1;
                    if (BUSY_CYC > 0) begin
                        state_nxt = MC_BUSY;
                        cnt_nxt   = LOAD;
                    end else begin
                        state_nxt = MC_DONE;
                    end
                end
            end
            MC_BUSY: begin
                hold = 1'b1;
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
                else           state_nxt = MC_DONE;
            end
            MC_DONE: state_nxt = MC_IDLE;
            default: state_nxt = MC_IDLE;
        endcase
    end

    assign busy = (state == MC_BUSY);
    assign done = (state == MC_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control for the 5-stage pipeline
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32,
    parameter int RA_W       = 5
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hif
);
    logic [RA_W-1:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [CNT_W-1:0] stall_cnt;
    logic             lw_stall, mc_busy, mc_done, mc_hold;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e;
    fwd_sel_e         fwd_a, fwd_b;

    assign rs1d = hif.Rs1D;
    assign rs2d = hif.Rs2D;
    assign rs1e = hif.Rs1E;
    assign rs2e = hif.Rs2E;
    assign rde  = hif.RdE;
    assign rdm  = hif.RdM;
    assign rdw  = hif.RdW;

    // M is the younger producer, so it has priority over W; x0 is never forwarded
    function automatic fwd_sel_e fwd_select(input logic [RA_W-1:0] rs,
                                            input logic [RA_W-1:0] rd_m,
                                            input logic [RA_W-1:0] rd_w,
                                            input logic            we_m,
                                            input logic            we_w);
        if (we_m && rd_m == rs && rd_m != '0)      return FWD_MEM;
        else if (we_w && rd_w == rs && rd_w != '0) return FWD_WB;
        else                                       return FWD_RF;
    endfunction

    assign lw_stall = hif.ResultSrcE0 && rde != '0 && (rde == rs1d || rde == rs2d);

    mc_sequencer #(.MC_LATENCY(MC_LATENCY)) u_mc (
        .clk      (clk),
        .reset    (reset),
        .McStartE (hif.McStartE),
        .PCSrcE   (hif.PCSrcE),
        .busy     (mc_busy),
        .done     (mc_done),
        .hold     (mc_hold)
    );

    always_comb begin
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (!reset) begin
            fwd_a = fwd_select(rs1e, rdm, rdw, hif.RegWriteM, hif.RegWriteW);
            fwd_b = fwd_select(rs2e, rdm, rdw, hif.RegWriteM, hif.RegWriteW);
            if (mc_hold) begin
                // E is frozen on the multi-cycle op: load-use and redirect wait
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_d = 1'b0;
                flush_e = 1'b0;
            end else begin
                stall_f = lw_stall;
                stall_d = lw_stall;
                flush_d = hif.PCSrcE;
                flush_e = lw_stall | hif.PCSrcE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        stall_cnt <= '0;
        else if (stall_f) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign hif.StallF      = stall_f;
    assign hif.StallD      = stall_d;
    assign hif.StallE      = stall_e;
    assign hif.FlushD      = flush_d;
    assign hif.FlushE      = flush_e;
    assign hif.ForwardAE   = fwd_a;
    assign hif.ForwardBE   = fwd_b;
    assign hif.McBusyE     = mc_busy;
    assign hif.McDoneE     = mc_done;
    assign hif.StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) hif ();
    hazard_ctrl_if #(.RA_W(5), .CNT_W(4))  hif2 ();

    hazard_ctrl #(.MC_LATENCY(4), .CNT_W(32), .RA_W(5)) dut  (.clk(clk), .reset(reset), .hif(hif));
    hazard_ctrl #(.MC_LATENCY(2), .CNT_W(4),  .RA_W(5)) dut2 (.clk(clk), .reset(reset), .hif(hif2));

    assign hif2.Rs1D        = hif.Rs1D;
    assign hif2.Rs2D        = hif.Rs2D;
    assign hif2.Rs1E        = hif.Rs1E;
    assign hif2.Rs2E        = hif.Rs2E;
    assign hif2.RdE         = hif.RdE;
    assign hif2.RdM         = hif.RdM;
    assign hif2.RdW         = hif.RdW;
    assign hif2.RegWriteM   = hif.RegWriteM;
    assign hif2.RegWriteW   = hif.RegWriteW;
    assign hif2.ResultSrcE0 = hif.ResultSrcE0;
    assign hif2.PCSrcE      = hif.PCSrcE;
    assign hif2.McStartE    = hif.McStartE;

    task automatic clear_inputs();
        hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
        hif.RdE  = '0; hif.RdM  = '0; hif.RdW  = '0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.ResultSrcE0 = 1'b0;
        hif.PCSrcE = 1'b0; hif.McStartE = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1;
        #1;
        tests++; if (hif.StallF !== 1'b0) begin fails++; $display("FAIL rst_stallf: got %b expected 0", hif.StallF); end
        tests++; if (hif.StallE !== 1'b0) begin fails++; $display("FAIL rst_stalle: got %b expected 0", hif.StallE); end
        tests++; if (hif.FlushD !== 1'b1 || hif.FlushE !== 1'b1) begin fails++; $display("FAIL rst_flush: got %b%b expected 11", hif.FlushD, hif.FlushE); end
        tests++; if (hif.ForwardAE !== 2'b00) begin fails++; $display("FAIL rst_fwd: got %b expected 00", hif.ForwardAE); end
        tests++; if (hif.McBusyE !== 1'b0 || hif.McDoneE !== 1'b0) begin fails++; $display("FAIL rst_mc: got %b%b expected 00", hif.McBusyE, hif.McDoneE); end
        tests++; if (hif.StallCycles !== 32'd0) begin fails++; $display("FAIL rst_cnt: got %0d expected 0", hif.StallCycles); end
        reset = 1'b0;
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        hif.Rs1E = 5'd5; hif.Rs2E = 5'd5;
        hif.RdM = 5'd5; hif.RegWriteM = 1'b1;
        hif.RdW = 5'd5; hif.RegWriteW = 1'b1;
        #1;
        tests++; if (hif.ForwardAE !== 2'b10) begin fails++; $display("FAIL fwd_a_mem: got %b expected 10", hif.ForwardAE); end
        tests++; if (hif.ForwardBE !== 2'b10) begin fails++; $display("FAIL fwd_b_mem: got %b expected 10", hif.ForwardBE); end
        hif.RegWriteM = 1'b0;
        #1;
        tests++; if (hif.ForwardAE !== 2'b01) begin fails++; $display("FAIL fwd_a_wb: got %b expected 01", hif.ForwardAE); end
        hif.RegWriteM = 1'b1; hif.RdM = 5'd0; hif.RdW = 5'd0; hif.Rs1E = 5'd0;
        hif.Rs2E = 5'd3;
        #1;
        tests++; if (hif.ForwardAE !== 2'b00) begin fails++; $display("FAIL fwd_a_x0: got %b expected 00", hif.ForwardAE); end
        hif.RdW = 5'd3;
        #1;
        tests++; if (hif.ForwardBE !== 2'b01) begin fails++; $display("FAIL fwd_b_wb: got %b expected 01", hif.ForwardBE); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        #1;
        tests++; if (hif.StallF !== 1'b1 || hif.StallD !== 1'b1) begin fails++; $display("FAIL lw_stall: got %b%b expected 11", hif.StallF, hif.StallD); end
        tests++; if (hif.FlushE !== 1'b1 || hif.FlushD !== 1'b0 || hif.StallE !== 1'b0) begin fails++; $display("FAIL lw_flush: got fe=%b fd=%b se=%b expected 1 0 0", hif.FlushE, hif.FlushD, hif.StallE); end
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (hif.StallCycles !== 32'd1) begin fails++; $display("FAIL lw_cnt: got %0d expected 1", hif.StallCycles); end
        hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd0; hif.Rs1D = 5'd0;
        #1;
        tests++; if (hif.StallF !== 1'b0 || hif.FlushE !== 1'b0) begin fails++; $display("FAIL lw_x0: got %b%b expected 00", hif.StallF, hif.FlushE); end
        hif.RdE = 5'd7; hif.Rs1D = 5'd7; hif.PCSrcE = 1'b1;
        #1;
        tests++; if (hif.FlushD !== 1'b1 || hif.FlushE !== 1'b1 || hif.StallF !== 1'b1) begin fails++; $display("FAIL lw_branch: got fd=%b fe=%b sf=%b expected 1 1 1", hif.FlushD, hif.FlushE, hif.StallF); end
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (hif.StallCycles !== 32'd2) begin fails++; $display("FAIL lw_cnt2: got %0d expected 2", hif.StallCycles); end
    endtask

    task automatic test_multicycle();
        clear_inputs();
        hif.McStartE = 1'b1;
        #1;
        tests++; if (hif.StallE !== 1'b1 || hif.StallF !== 1'b1 || hif.FlushE !== 1'b0) begin fails++; $display("FAIL mc_c1: got se=%b sf=%b fe=%b expected 1 1 0", hif.StallE, hif.StallF, hif.FlushE); end
        tests++; if (hif.McBusyE !== 1'b0) begin fails++; $display("FAIL mc_c1_busy: got %b expected 0", hif.McBusyE); end
        tests++; if (hif2.StallE !== 1'b1) begin fails++; $display("FAIL mc2_c1: got %b expected 1", hif2.StallE); end
        next_cycle();
        hif.McStartE = 1'b0;
        #1;
        tests++; if (hif.McBusyE !== 1'b1 || hif.StallE !== 1'b1) begin fails++; $display("FAIL mc_c2: got busy=%b se=%b expected 1 1", hif.McBusyE, hif.StallE); end
        tests++; if (hif2.McDoneE !== 1'b1 || hif2.McBusyE !== 1'b0 || hif2.StallE !== 1'b0) begin fails++; $display("FAIL mc2_c2: got done=%b busy=%b se=%b expected 1 0 0", hif2.McDoneE, hif2.McBusyE, hif2.StallE); end
        next_cycle();
        hif.PCSrcE = 1'b1; hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
        #1;
        tests++; if (hif.McBusyE !== 1'b1 || hif.StallE !== 1'b1 || hif.McDoneE !== 1'b0) begin fails++; $display("FAIL mc_c3: got busy=%b se=%b done=%b expected 1 1 0", hif.McBusyE, hif.StallE, hif.McDoneE); end
        tests++; if (hif.FlushD !== 1'b0 || hif.FlushE !== 1'b0) begin fails++; $display("FAIL mc_c3_flush: got %b%b expected 00", hif.FlushD, hif.FlushE); end
        next_cycle();
        clear_inputs();
        hif.McStartE = 1'b1;
        #1;
        tests++; if (hif.McDoneE !== 1'b1 || hif.McBusyE !== 1'b0 || hif.StallE !== 1'b0) begin fails++; $display("FAIL mc_c4: got done=%b busy=%b se=%b expected 1 0 0", hif.McDoneE, hif.McBusyE, hif.StallE); end
        tests++; if (hif.StallCycles !== 32'd5) begin fails++; $display("FAIL mc_cnt: got %0d expected 5", hif.StallCycles); end
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (hif.McDoneE !== 1'b0 || hif.McBusyE !== 1'b0 || hif.StallE !== 1'b0) begin fails++; $display("FAIL mc_c5: got done=%b busy=%b se=%b expected 0 0 0", hif.McDoneE, hif.McBusyE, hif.StallE); end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_branch_vs_mc();
        clear_inputs();
        hif.McStartE = 1'b1; hif.PCSrcE = 1'b1;
        #1;
        tests++; if (hif.FlushD !== 1'b1 || hif.FlushE !== 1'b1 || hif.StallE !== 1'b0 || hif.StallF !== 1'b0) begin fails++; $display("FAIL br_mc: got fd=%b fe=%b se=%b sf=%b expected 1 1 0 0", hif.FlushD, hif.FlushE, hif.StallE, hif.StallF); end
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (hif.McBusyE !== 1'b0 || hif.McDoneE !== 1'b0) begin fails++; $display("FAIL br_mc_state: got busy=%b done=%b expected 0 0", hif.McBusyE, hif.McDoneE); end
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        hif.McStartE = 1'b1;
        next_cycle();
        hif.McStartE = 1'b0;
        next_cycle();
        #1;
        tests++; if (hif.McBusyE !== 1'b1) begin fails++; $display("FAIL rb_busy: got %b expected 1", hif.McBusyE); end
        reset = 1'b1;
        hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1;
        #1;
        tests++; if (hif.StallF !== 1'b0 || hif.StallD !== 1'b0 || hif.StallE !== 1'b0) begin fails++; $display("FAIL rb_stall: got %b%b%b expected 000", hif.StallF, hif.StallD, hif.StallE); end
        tests++; if (hif.FlushD !== 1'b1 || hif.FlushE !== 1'b1 || hif.ForwardAE !== 2'b00) begin fails++; $display("FAIL rb_flush: got fd=%b fe=%b fa=%b expected 1 1 00", hif.FlushD, hif.FlushE, hif.ForwardAE); end
        next_cycle();
        tests++; if (hif.McBusyE !== 1'b0 || hif.McDoneE !== 1'b0) begin fails++; $display("FAIL rb_mc: got busy=%b done=%b expected 0 0", hif.McBusyE, hif.McDoneE); end
        tests++; if (hif.StallCycles !== 32'd0) begin fails++; $display("FAIL rb_cnt: got %0d expected 0", hif.StallCycles); end
        reset = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        tests++; if (hif.McBusyE !== 1'b0 || hif.McDoneE !== 1'b0) begin fails++; $display("FAIL rb_after: got busy=%b done=%b expected 0 0", hif.McBusyE, hif.McDoneE); end
    endtask

    task automatic test_cnt_wrap();
        logic [3:0] exp_small;
        clear_inputs();
        hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
        for (int i = 1; i <= 18; i++) begin
            next_cycle();
            if (i == 15 || i == 16 || i == 18) begin
                exp_small = 4'(i % 16);
                tests++; if (hif2.StallCycles !== exp_small) begin fails++; $display("FAIL wrap_%0d: got %0d expected %0d", i, hif2.StallCycles, exp_small); end
            end
        end
        tests++; if (hif.StallCycles !== 32'd18) begin fails++; $display("FAIL wrap_wide: got %0d expected 18", hif.StallCycles); end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_branch_vs_mc();
        test_reset_mid_busy();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
